// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a send/txbusy handshake.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    wdata,
    input  logic          wr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [7:0]    txd,
    output logic          send,
    input  logic          txbusy,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;

    assign full  = (cnt == DEPTH);
    assign empty = (cnt == '0);
    assign count = cnt;
    assign send  = (state == SEND);
    // a write while full is dropped even if a pop frees a slot on the same edge
    assign push  = wr && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            txd   <= '0;
        end else begin
            state <= state_next;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
                txd  <= mem[rptr];
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !txbusy) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (txbusy) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!txbusy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef UART_TX_FIFO_OVF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (wr && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
`else
    logic ovf_clr_unused;
    assign ovf_clr_unused = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based transmit model.
// Define UART_TX_FIFO_OVF_EN here as for the RTL to check the overflow build.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] wdata;
    logic       wr;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic [7:0] txd;
    logic       send;
    logic       txbusy;
    logic       overflow;
    logic       ovf_clr;

    always #5 clk = ~clk;

    uart_tx_fifo #(.AW(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wdata    (wdata),
        .wr       (wr),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .txd      (txd),
        .send     (send),
        .txbusy   (txbusy),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference: bytes waiting, the byte on the line, and handshake progress
    byte unsigned q[$];
    logic [7:0]   m_txd;
    bit           requesting;
    bit           awaiting_idle;
    bit           m_ovf;

    // emulated transmitter driving txbusy
    bit u_auto;
    bit u_rand;
    int u_gap;
    int u_len;
    int u_wait;
    int u_left;

    int sends_seen;
    bit prev_send;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_txd         = 8'h00;
        requesting    = 1'b0;
        awaiting_idle = 1'b0;
        m_ovf         = 1'b0;
    endtask

    task automatic model_edge();
        bit take;
        bit start;
        if (!reset_n) begin
            model_reset();
            return;
        end
        take  = wr && (q.size() < DEPTH);
        start = !requesting && !awaiting_idle && (q.size() > 0) && !txbusy;
`ifdef UART_TX_FIFO_OVF_EN
        if (wr && !take) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
`endif
        if (start) begin
            m_txd      = q.pop_front();
            requesting = 1'b1;
        end else if (requesting && txbusy) begin
            requesting    = 1'b0;
            awaiting_idle = 1'b1;
        end else if (awaiting_idle && !txbusy) begin
            awaiting_idle = 1'b0;
        end
        if (take) q.push_back(wdata);
    endtask

    task automatic compare_all();
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("send", 32'(send), 32'(requesting));
        check("txd", 32'(txd), 32'(m_txd));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic uart_tick();
        if (!u_auto) return;
        if (txbusy) begin
            u_left--;
            if (u_left <= 0) txbusy = 1'b0;
        end else if (requesting) begin
            if (u_wait >= u_gap) begin
                txbusy = 1'b1;
                u_left = u_len;
                u_wait = 0;
                if (u_rand) begin
                    u_gap = $urandom_range(0, 4);
                    u_len = $urandom_range(1, 6);
                end
            end else begin
                u_wait++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (send && !prev_send) sends_seen++;
        prev_send = send;
        uart_tick();
    endtask

    task automatic drain();
        int budget;
        wr      = 1'b0;
        u_auto  = 1'b1;
        budget  = 0;
        while ((q.size() != 0 || requesting || awaiting_idle || txbusy) && budget < 2000) begin
            step();
            budget++;
        end
        check("drain_done", 32'(budget < 2000), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        wr      = 1'b0;
        wdata   = 8'h00;
        txbusy  = 1'b0;
        ovf_clr = 1'b0;
        u_auto  = 1'b0;
        u_rand  = 1'b0;
        u_gap   = 2;
        u_len   = 20;
        u_wait  = 0;
        u_left  = 0;
        sends_seen = 0;
        prev_send  = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();

        // single byte and handshake
        wr = 1'b1; wdata = 8'h41;
        step();
        wr = 1'b0;
        check("single_not_yet", 32'(send), 32'd0);
        step();
        check("single_send", 32'(send), 32'd1);
        check("single_txd", 32'(txd), 32'h41);
        repeat (5) step();
        check("single_hold", 32'(send), 32'd1);
        txbusy = 1'b1;
        step();
        check("handshake_drop", 32'(send), 32'd0);
        repeat (10) step();
        txbusy = 1'b0;
        repeat (5) step();
        check("handshake_empty", 32'(empty), 32'd1);

        // burst of 16 held off by txbusy, then drained in order
        txbusy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; wdata = 8'(i);
            step();
        end
        wr = 1'b0;
        check("burst_full", 32'(full), 32'd1);
        sends_seen = 0;
        u_gap = 2; u_len = 20; u_wait = 0; u_left = 1;
        drain();
        check("burst_sends", 32'(sends_seen), 32'd16);

        // overflow
        u_auto = 1'b0;
        txbusy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; wdata = 8'($urandom_range(0, 8'hED));
            step();
        end
        wr = 1'b1; wdata = 8'hEE;
        step();
        wr = 1'b0;
        check("ovf_count", 32'(count), 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
        step();
        check("ovf_set", 32'(overflow), 32'd1);
`else
        step();
        check("ovf_off", 32'(overflow), 32'd0);
`endif
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        step();
        check("ovf_clr", 32'(overflow), 32'd0);
        u_left = 1;
        drain();

        // write on the same edge as a pop
        u_auto = 1'b0;
        txbusy = 1'b1;
        wr = 1'b1; wdata = 8'h5A;
        step();
        wr = 1'b0;
        step();
        txbusy = 1'b0; wr = 1'b1; wdata = 8'hA5;
        step();
        wr = 1'b0;
        check("simul_count", 32'(count), 32'd1);
        check("simul_send", 32'(send), 32'd1);
        check("simul_txd", 32'(txd), 32'h5A);
        u_left = 1;
        drain();

        // randomized traffic across many pointer wraps
        u_rand = 1'b1;
        u_auto = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            wr      = ($urandom_range(0, 99) < 40);
            wdata   = 8'($urandom);
            ovf_clr = ($urandom_range(0, 99) < 5);
            step();
        end
        ovf_clr = 1'b0;
        drain();

        // reset in the middle of a transfer
        u_auto = 1'b0;
        u_rand = 1'b0;
        txbusy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr = 1'b1; wdata = 8'(8'h30 + i);
            step();
        end
        wr = 1'b0;
        check("rst_pre_send", 32'(send), 32'd1);
        check("rst_pre_count", 32'(count), 32'd5);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_send", 32'(send), 32'd0);
        check("rst_async_count", 32'(count), 32'd0);
        check("rst_async_empty", 32'(empty), 32'd1);
        check("rst_async_txd", 32'(txd), 32'd0);
        model_reset();
        repeat (2) step();
        #2 reset_n = 1'b1;
        sends_seen = 0;
        repeat (10) step();
        check("rst_no_send", 32'(sends_seen), 32'd0);
        wr = 1'b1; wdata = 8'h77;
        step();
        wr = 1'b0;
        step();
        check("rst_new_send", 32'(send), 32'd1);
        check("rst_new_txd", 32'(txd), 32'h77);
        u_left = 1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter AW, default 4, log2 of FIFO depth (depth = 2**AW bytes).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wdata  input  8  byte to enqueue.
REQ-005 SHALL have port wr  input  1  enqueue strobe, one byte per cycle high.
REQ-006 SHALL have port full  output  1  high when count == 2**AW.
REQ-007 SHALL have port empty  output  1  high when count == 0.
REQ-008 SHALL have port count  output  AW+1  bytes currently stored.
REQ-009 SHALL have port txd  output  8  byte presented to the UART transmitter din.
REQ-010 SHALL have port send  output  1  transmit request to the UART transmitter.
REQ-011 SHALL have port txbusy  input  1  transmitter busy flag from the UART.
REQ-012 SHALL have port overflow  output  1  sticky write-while-full flag.
REQ-013 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-014 SHALL store bytes in a circular buffer of 2**AW entries; read and write pointers wrap modulo 2**AW.
REQ-015 SHALL accept wr only when full is low; a write while full SHALL be dropped, leaving storage, pointers and count unchanged.
REQ-016 SHALL reject a write while full even when a pop occurs in the same cycle.
REQ-017 SHALL update count by +1 on write only, -1 on pop only, and leave it unchanged on simultaneous write and pop.
REQ-018 SHALL derive full, empty and count from registered state only; they SHALL change on the edge after the event.
REQ-019 SHALL implement the transmit FSM with states IDLE, SEND and DRAIN.
REQ-020 IDLE: if !empty and !txbusy, SHALL register txd <= head byte, advance the read pointer (pop), set send=1 and go to SEND; otherwise SHALL stay in IDLE with send=0.
REQ-021 SEND: SHALL hold send=1 and txd stable until txbusy is sampled high, then set send=0 and go to DRAIN.
REQ-022 DRAIN: SHALL hold send=0 until txbusy is sampled low, then go to IDLE.
REQ-023 SHALL make send high on the second rising edge after the edge that samples wr into an empty FIFO, provided txbusy is low (write edge k, count=1 after k, send=1 after k+1).
REQ-024 SHALL pop exactly one byte per SEND entry; a byte SHALL never be transmitted twice or skipped.
REQ-025 SHALL leave txd holding the last transmitted byte while in IDLE/DRAIN.
REQ-026 SHALL give a minimum spacing of 3 cycles between successive send rising edges (SEND, DRAIN, IDLE).
REQ-027 SHALL accept writes in every FSM state, including the write edge that coincides with a pop.

Reset
REQ-028 When reset_n is low, SHALL force asynchronously: state=IDLE, send=0, txd=0x00, pointers=0, count=0, empty=1, full=0, overflow=0.
REQ-029 Reset mid-transfer SHALL discard all stored bytes and drop send immediately, without waiting for a clock edge.
REQ-030 After reset_n deasserts, SHALL issue no send until a new byte is written.
REQ-031 Storage contents SHALL NOT require reset.

Configuration
REQ-032 With macro UART_TX_FIFO_OVF_EN defined, overflow SHALL be set on the edge after any dropped write.
REQ-033 With UART_TX_FIFO_OVF_EN defined, overflow SHALL stay high until ovf_clr is sampled high; set wins over clear in the same cycle.
REQ-034 With UART_TX_FIFO_OVF_EN undefined, overflow SHALL be constant 0, ovf_clr SHALL be ignored, and no overflow register SHALL be inferred; the port list SHALL be identical in both builds.

Verification
REQ-035 Single byte: AW=4, txbusy=0, write 0x41 -> send=1 two edges later with txd=0x41; hold txbusy=0 for 5 cycles -> send remains 1, txd stays 0x41.
REQ-036 Handshake: from REQ-035, raise txbusy -> send=0 next edge; lower txbusy after 10 cycles -> with FIFO empty, send stays 0, empty=1.
REQ-037 Burst and order: write 0x00..0x0F back-to-back, then model txbusy as a 20-cycle pulse starting 2 cycles after each send -> 16 sends with txd 0x00..0x0F in order, full=1 after the 16th write.
REQ-038 Overflow: fill 16 bytes with txbusy=1, write 0xEE -> count stays 16, 0xEE is never sent, overflow=1 (OVF_EN build) or 0 (non-OVF_EN build); pulse ovf_clr -> overflow=0.
REQ-039 Wrap and simultaneous events: write/transmit 40 bytes with a write coinciding with a pop -> count unchanged on that edge, output sequence matches input across pointer wrap.
REQ-040 Reset mid-operation: 5 bytes queued, send=1; assert reset_n=0 between edges -> send=0 and count=0 immediately; release -> no send until a new write.
